// File: rtl/led_pkg.sv
// Shared constants, state encoding and byte-lane mapping for the LED frame buffer.
package led_pkg;

    localparam int unsigned LED_FB_BYTES = 32;
    localparam int unsigned LED_ADDR_W   = 5;
    localparam int unsigned LED_ROWS     = 8;
    localparam int unsigned LED_DEVS     = 4;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } led_state_e;

    // Byte 0 sits in the top bits so the frame reads MSB-first along the chain.
    function automatic logic [7:0] byte_lsb(input logic [LED_ADDR_W-1:0] addr);
        return 8'd248 - {addr, 3'b000};
    endfunction

endpackage

// File: rtl/led_framebuf.sv
// Double-buffered 256-bit frame store with sequenced clear and atomic commit.
// Define LED_FB_READBACK_EN to add the registered shadow readback port.
module led_framebuf
    import led_pkg::*;
#(
    parameter logic [7:0] BLANK       = 8'h00,
    parameter bit         AUTO_COMMIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [LED_ADDR_W-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  commit,
    input  logic                  clear,
    output logic                  busy,
    output logic [255:0]          fb_out,
    output logic [7:0]            frame_cnt
`ifdef LED_FB_READBACK_EN
    ,
    input  logic [LED_ADDR_W-1:0] rd_addr,
    output logic [7:0]            rd_data
`endif
);

    led_state_e            state_q, state_d;
    logic [LED_ADDR_W-1:0] ptr_q, ptr_d;
    logic [255:0]          shadow_q, shadow_d;
    logic [255:0]          fb_q, fb_d;
    logic                  pending_q, pending_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  commit_fire;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        shadow_d    = shadow_q;
        fb_d        = fb_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        commit_fire = 1'b0;
        wr_ready    = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                wr_ready = 1'b1;
                busy     = pending_q;
                if (clear) begin
                    // Clear wins over a same-cycle write; a same-cycle commit waits for it.
                    state_d   = ST_CLEAR;
                    ptr_d     = '0;
                    pending_d = commit;
                end else begin
                    if (wr_valid) begin
                        shadow_d[byte_lsb(wr_addr) +: 8] = wr_data;
                    end
                    commit_fire = commit | pending_q;
                    pending_d   = 1'b0;
                end
            end
            ST_CLEAR: begin
                busy                           = 1'b1;
                shadow_d[byte_lsb(ptr_q) +: 8] = BLANK;
                ptr_d                          = ptr_q + 5'd1;
                if (commit) begin
                    pending_d = 1'b1;
                end
                if (ptr_q == 5'(LED_FB_BYTES - 1)) begin
                    // Merged pending commit lands with the final blank byte, so the
                    // first IDLE cycle already shows the blank frame.
                    state_d     = ST_IDLE;
                    commit_fire = pending_q | commit | AUTO_COMMIT;
                    pending_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit_fire) begin
            fb_d  = shadow_d;
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            shadow_q  <= {LED_FB_BYTES{BLANK}};
            fb_q      <= {LED_FB_BYTES{BLANK}};
            pending_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            shadow_q  <= shadow_d;
            fb_q      <= fb_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign fb_out    = fb_q;
    assign frame_cnt = cnt_q;

`ifdef LED_FB_READBACK_EN
    logic [7:0] rd_data_q;

    // Reads the pre-write shadow, so a same-cycle write returns the old byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= shadow_q[byte_lsb(rd_addr) +: 8];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule
